// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths: frame geometry,
// line idle level and the receiver FSM state encoding.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Data bits per frame (8N1).
    localparam int UART_DATA_BITS = 8;

    // Level of an idle line; a start bit is the opposite level.
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Receiver FSM states, kept as plain constants for legacy tool flows.
    localparam int          UART_STATE_W = 3;
    localparam logic [2:0]  ST_IDLE      = 3'd0;
    localparam logic [2:0]  ST_START     = 3'd1;
    localparam logic [2:0]  ST_DATA      = 3'd2;
    localparam logic [2:0]  ST_STOP      = 3'd3;
    localparam logic [2:0]  ST_BREAK     = 3'd4;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for an asynchronous input pin. Both flops reset to
// RESET_VAL so an idle-high line does not look like an edge out of reset.
//
// Ports:
//   clk      in   system clock
//   m_reset  in   synchronous active-high reset
//   async_i  in   asynchronous input
//   sync_o   out  synchronised copy of async_i (two clk cycles of latency)
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic m_reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk) begin
        if (m_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
// 8N1 UART receiver: synchronises the serial line, samples each bit in its
// middle, rejects false starts, flags framing errors and presents complete
// bytes through a one-byte holding register on a valid/ready interface.
//
// Ports:
//   clk           in   system clock (only clock)
//   m_reset       in   synchronous active-high reset
//   uart_rxd      in   asynchronous serial line, idles high
//   rx_valid      out  byte available on rx_data
//   rx_data       out  received byte, LSB first on the wire
//   rx_ready      in   consumer accepts when rx_valid && rx_ready
//   rx_frame_err  out  one-cycle pulse: stop bit sampled low
//   rx_overrun    out  one-cycle pulse: good byte dropped, holding reg full
// -----------------------------------------------------------------------------
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 868,
    parameter int DATA_BITS      = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 m_reset,
    input  logic                 uart_rxd,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

    logic rxs;

    uart_rx_sync #(
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk     (clk),
        .m_reset (m_reset),
        .async_i (uart_rxd),
        .sync_o  (rxs)
    );

    logic [UART_STATE_W-1:0] state_q,   state_d;
    logic [CNT_W-1:0]        cyc_cnt_q, cyc_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]    shift_q,   shift_d;
    logic [DATA_BITS-1:0]    data_q,    data_d;
    logic                    valid_q,   valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q,   overrun_d;
    logic                    frame_good;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        state_d     = state_q;
        cyc_cnt_d   = cyc_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        frame_good  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rxs != UART_IDLE_LEVEL) begin
                    cyc_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                end
            end

            // Half a bit into the start bit: still low means a real start,
            // and every later sample then lands mid-bit.
            ST_START: begin
                if (cyc_cnt_q == HALF_LAST) begin
                    cyc_cnt_d = '0;
                    state_d   = (rxs == UART_IDLE_LEVEL) ? ST_IDLE : ST_DATA;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                end
            end

            // LSB arrives first, so shifting right leaves it in bit 0.
            ST_DATA: begin
                if (cyc_cnt_q == BIT_LAST) begin
                    cyc_cnt_d = '0;
                    shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (cyc_cnt_q == BIT_LAST) begin
                    cyc_cnt_d = '0;
                    if (rxs == UART_IDLE_LEVEL) begin
                        frame_good = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                end
            end

            // Hold off until the line is released, so a break condition
            // yields exactly one error pulse.
            ST_BREAK: begin
                if (rxs == UART_IDLE_LEVEL) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Holding register: a consume and a new byte in the same cycle
        // replace the byte without losing the valid flag.
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (frame_good) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (m_reset) begin
            state_q     <= ST_IDLE;
            cyc_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_cnt_q   <= cyc_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_valid     = valid_q;
    assign rx_data      = data_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

endmodule : uart_rx_deser

// File: tb/tb_uart_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser
// Self-checking bench for uart_rx_deser with CYCLES_PER_BIT = 16. Frames are
// generated as bit-level waveforms; expected bytes, pulse counts and latency
// come from the frame contents and the latency formula.
// -----------------------------------------------------------------------------
module tb_uart_rx_deser;

    localparam int CPB     = 16;
    localparam int LATENCY = 3 + CPB / 2 + 9 * CPB;   // 155
    localparam int FRAME   = 10 * CPB;                // one 8N1 frame

    logic       clk;
    logic       m_reset;
    logic       uart_rxd;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    int tests = 0;
    int fails = 0;

    // Observation counters, sampled on the falling edge.
    int         fe_cycles  = 0;
    int         ov_cycles  = 0;
    int         valid_seen = 0;
    int         stab_err   = 0;
    int         excl_err   = 0;
    logic [7:0] acc_q[$];
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    uart_rx_deser #(
        .CYCLES_PER_BIT (CPB),
        .DATA_BITS      (8)
    ) dut (
        .clk          (clk),
        .m_reset      (m_reset),
        .uart_rxd     (uart_rxd),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_reset) begin
            prev_valid = 1'b0;
        end else begin
            if (rx_frame_err) fe_cycles++;
            if (rx_overrun) ov_cycles++;
            if (rx_valid) valid_seen++;
            if (rx_frame_err && rx_overrun) excl_err++;
            // A held byte may neither vanish nor change without a handshake.
            if (prev_valid && !prev_ready && (!rx_valid || rx_data !== prev_data)) stab_err++;
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
            prev_valid = rx_valid;
            prev_ready = rx_ready;
            prev_data  = rx_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2 ms");
        $fatal(1);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        fe_cycles  = 0;
        ov_cycles  = 0;
        valid_seen = 0;
        acc_q.delete();
    endtask

    // Start bit, 8 data bits LSB first, one stop bit of the given level.
    task automatic drive_frame(input logic [7:0] b, input logic stop_lvl);
        logic [9:0] bits;
        bits = {stop_lvl, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            wait_cycles(CPB);
        end
    endtask

    task automatic test_reset();
        m_reset  = 1'b1;
        uart_rxd = 1'b1;
        rx_ready = 1'b1;
        wait_cycles(3);
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        tests++; if ({rx_frame_err, rx_overrun} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b expected 00", {rx_frame_err, rx_overrun}); end
        m_reset = 1'b0;
        clear_stats();
        wait_cycles(1000);
        tests++; if (valid_seen !== 0) begin fails++; $display("FAIL idle_valid: got %0d valid cycles expected 0", valid_seen); end
        tests++; if (fe_cycles + ov_cycles !== 0) begin fails++; $display("FAIL idle_pulses: got %0d expected 0", fe_cycles + ov_cycles); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL idle_data: got %h expected 00", rx_data); end
    endtask

    task automatic test_latency();
        int         lat;
        logic [7:0] d_found;
        logic       v_next;
        lat     = 0;
        d_found = 8'h00;
        v_next  = 1'b1;
        clear_stats();
        rx_ready = 1'b1;
        fork
            drive_frame(8'hA5, 1'b1);
            begin
                for (int i = 1; i <= 400 && lat == 0; i++) begin
                    @(posedge clk); #1;
                    if (rx_valid) begin
                        lat     = i;
                        d_found = rx_data;
                    end
                end
                if (lat != 0) begin
                    wait_cycles(1);
                    v_next = rx_valid;
                end
            end
        join
        wait_cycles(20);
        tests++; if (lat !== LATENCY) begin fails++; $display("FAIL latency: got %0d cycles expected %0d", lat, LATENCY); end
        tests++; if (d_found !== 8'hA5) begin fails++; $display("FAIL latency_data: got %h expected a5", d_found); end
        tests++; if (v_next !== 1'b0) begin fails++; $display("FAIL valid_drop: got %b expected 0", v_next); end
        tests++; if (acc_q.size() !== 1) begin fails++; $display("FAIL latency_count: got %0d bytes expected 1", acc_q.size()); end
    endtask

    task automatic test_glitch();
        clear_stats();
        uart_rxd = 1'b0;
        wait_cycles(5);
        uart_rxd = 1'b1;
        wait_cycles(40);
        tests++; if (valid_seen + fe_cycles + ov_cycles !== 0) begin fails++; $display("FAIL glitch_reject: got %0d active cycles expected 0", valid_seen + fe_cycles + ov_cycles); end
        drive_frame(8'h3C, 1'b1);
        wait_cycles(20);
        tests++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h3C) begin fails++; $display("FAIL glitch_recover: got %0d bytes first %h expected 1 byte 3c", acc_q.size(), acc_q[0]); end
    endtask

    task automatic test_frame_err();
        clear_stats();
        drive_frame(8'h81, 1'b0);
        wait_cycles(40);          // line held low: break
        uart_rxd = 1'b1;
        wait_cycles(20);
        tests++; if (fe_cycles !== 1) begin fails++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", fe_cycles); end
        tests++; if (valid_seen !== 0) begin fails++; $display("FAIL frame_err_valid: got %0d valid cycles expected 0", valid_seen); end
        drive_frame(8'h7E, 1'b1);
        wait_cycles(20);
        tests++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h7E) begin fails++; $display("FAIL frame_err_recover: got %0d bytes first %h expected 1 byte 7e", acc_q.size(), acc_q[0]); end
        tests++; if (fe_cycles !== 1 || ov_cycles !== 0) begin fails++; $display("FAIL frame_err_after: got fe=%0d ov=%0d expected fe=1 ov=0", fe_cycles, ov_cycles); end
    endtask

    task automatic test_overrun();
        clear_stats();
        rx_ready = 1'b0;
        drive_frame(8'h11, 1'b1);
        drive_frame(8'h22, 1'b1);
        wait_cycles(20);
        tests++; if (ov_cycles !== 1) begin fails++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ov_cycles); end
        tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin fails++; $display("FAIL overrun_hold: got valid=%b data=%h expected valid=1 data=11", rx_valid, rx_data); end
        tests++; if (fe_cycles !== 0) begin fails++; $display("FAIL overrun_no_fe: got %0d expected 0", fe_cycles); end
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        wait_cycles(2);
        tests++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h11 || rx_valid !== 1'b0) begin fails++; $display("FAIL overrun_drain: got %0d bytes first %h valid=%b expected 1 byte 11 valid=0", acc_q.size(), acc_q[0], rx_valid); end

        // Same pair, with ready raised only on the 0x22 completion cycle.
        clear_stats();
        fork
            begin
                drive_frame(8'h11, 1'b1);
                drive_frame(8'h22, 1'b1);
            end
            begin
                wait_cycles(FRAME + LATENCY - 1);
                rx_ready = 1'b1;
                wait_cycles(1);
                rx_ready = 1'b0;
            end
        join
        wait_cycles(10);
        tests++; if (ov_cycles !== 0) begin fails++; $display("FAIL consume_no_overrun: got %0d cycles expected 0", ov_cycles); end
        tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin fails++; $display("FAIL consume_replace: got valid=%b data=%h expected valid=1 data=22", rx_valid, rx_data); end
        tests++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h11) begin fails++; $display("FAIL consume_accept: got %0d bytes first %h expected 1 byte 11", acc_q.size(), acc_q[0]); end
        rx_ready = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_mid_reset();
        clear_stats();
        rx_ready = 1'b0;
        drive_frame(8'h66, 1'b1);   // parked in the holding register
        wait_cycles(4);
        fork
            drive_frame(8'hF0, 1'b1);
            begin
                wait_cycles(6 * CPB + 4);   // inside data bit 5
                m_reset = 1'b1;
                wait_cycles(2);
                tests++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin fails++; $display("FAIL mid_reset_clear: got valid=%b data=%h expected valid=0 data=00", rx_valid, rx_data); end
                m_reset = 1'b0;
            end
        join
        clear_stats();
        rx_ready = 1'b1;
        wait_cycles(4 * CPB);
        tests++; if (valid_seen + fe_cycles !== 0) begin fails++; $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", valid_seen + fe_cycles); end
        drive_frame(8'h5A, 1'b1);
        wait_cycles(20);
        tests++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h5A) begin fails++; $display("FAIL mid_reset_recover: got %0d bytes first %h expected 1 byte 5a", acc_q.size(), acc_q[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         gap;
        clear_stats();
        rx_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            drive_frame(b, 1'b1);
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
            if (gap > 0) wait_cycles(gap);
        end
        wait_cycles(20);
        tests++; if (acc_q.size() !== exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d bytes expected %0d", acc_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            tests++; if (acc_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_byte%0d: got %h expected %h", i, acc_q[i], exp_q[i]); end
        end
        tests++; if (fe_cycles + ov_cycles !== 0) begin fails++; $display("FAIL b2b_pulses: got %0d expected 0", fe_cycles + ov_cycles); end
    endtask

    task automatic test_handshake_rules();
        tests++; if (stab_err !== 0) begin fails++; $display("FAIL hold_stability: got %0d violations expected 0", stab_err); end
        tests++; if (excl_err !== 0) begin fails++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", excl_err); end
    endtask

    initial begin
        m_reset  = 1'b1;
        uart_rxd = 1'b1;
        rx_ready = 1'b1;
        test_reset();
        test_latency();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_mid_reset();
        test_back_to_back();
        test_handshake_rules();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_uart_rx_deser

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Receives an asynchronous 8N1 serial line and deserialises it into bytes.
- Presents each byte on a valid/ready byte interface that connects directly to uartprobe's rx_valid/rx_data/rx_ready inputs.
- Sits between the board UART pin and the probe command decoder.
- Includes line synchronisation, mid-bit sampling, false-start rejection, framing-error detection and a one-byte output holding register with overrun detection.

Parameters:
- CYCLES_PER_BIT, 868: clk cycles per serial bit (100 MHz / 115200). Must be even and >= 4; other values are unsupported.
- DATA_BITS, 8: data bits per frame. Fixed at 8; exists only to size internal registers from the package constant.

Ports:
- clk  input  1  system clock; the only clock.
- m_reset  input  1  reset; synchronous, active-high.
- uart_rxd  input  1  asynchronous serial line; idles high.
- rx_valid  output  1  byte available on rx_data.
- rx_data  output  8  received byte; LSB is the first bit on the wire.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready at a rising edge.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values, applied at the first clk edge with m_reset=1: state IDLE; rx_valid=0; rx_data=8'h00; rx_frame_err=0; rx_overrun=0; both synchroniser flops=1; bit counter=0; cycle counter=0.
- Reset mid-frame or mid-handshake: the partial frame is discarded and any held byte is lost. No error pulse is generated.
- Synchroniser: 2 flops. All internal decisions use the second flop output, rxs.
- Cycle counter is $clog2(CYCLES_PER_BIT) bits. HALF = CYCLES_PER_BIT/2.
- IDLE: when rxs==0, clear the counters and go to START.
- START:
  - Count up to HALF-1, then sample rxs.
  - rxs==1: false start; return to IDLE with no pulse and no output.
  - rxs==0: clear the counter and go to DATA.
- DATA:
  - When the counter reaches CYCLES_PER_BIT-1, sample rxs into shift register bit[7], shifting right, and clear the counter.
  - After the 8th sample, go to STOP.
- STOP: when the counter reaches CYCLES_PER_BIT-1, sample rxs.
  - rxs==1: frame is good. Deliver it (see holding register) and go to IDLE.
  - rxs==0: pulse rx_frame_err for one cycle, discard the byte, go to BREAK.
- BREAK: wait for rxs==1, then go to IDLE. This stops a held-low line (break) from producing repeated frames or error pulses.
- Re-sync: IDLE accepts a new start edge the cycle after STOP completes. Back-to-back frames with exactly one stop bit must be received.
- Latency: from the uart_rxd falling edge (setup met) to rx_valid=1 is exactly 3 + HALF + 9*CYCLES_PER_BIT cycles, assuming the holding register is empty. This figure is normative.
- Holding register, evaluated on the cycle a good frame completes:
  - rx_valid==0: load rx_data and set rx_valid=1.
  - rx_valid==1 && rx_ready==1 (same-cycle consume): load the new byte; rx_valid stays 1; no overrun.
  - rx_valid==1 && rx_ready==0: keep the old byte, drop the new one, pulse rx_overrun for one cycle.
- Output handshake:
  - rx_valid && rx_ready with no frame completing: rx_valid=0 next cycle.
  - rx_data is stable whenever rx_valid=1.
  - rx_valid never drops without a handshake except on reset.
- rx_frame_err and rx_overrun are registered, mutually exclusive, and never asserted in consecutive cycles for the same frame.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK}
  - UART_DATA_BITS=8
  - UART_IDLE_LEVEL=1'b1
  - The uart_tx serialiser on the other side of uartprobe uses the same package.
- Sub-module uart_rx_sync: 2-flop synchroniser with reset value 1, reusable for other async pins.
- All sampling and FSM logic stays in uart_rx_deser.

Test Plan (CYCLES_PER_BIT=16, so latency = 3 + 8 + 144 = 155):
- Reset, then a line held high for 1000 cycles -> rx_valid, rx_frame_err and rx_overrun stay 0; rx_data=8'h00.
- Send frame 0xA5, rx_ready=1 -> rx_valid=1 exactly 155 cycles after the falling edge, rx_data=8'hA5, rx_valid=0 the next cycle.
- 5-cycle low glitch on an idle line -> no rx_valid and no error pulse. Then send 0x3C -> rx_data=8'h3C.
- Frame 0x81 with stop bit driven low, then the line held low for 40 cycles -> exactly one rx_frame_err pulse, no rx_valid. After the line returns high, frame 0x7E -> rx_data=8'h7E.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 8'h11, one rx_overrun pulse at the 0x22 stop sample. Repeat with rx_ready raised exactly on the 0x22 completion cycle -> no overrun; rx_data=8'h22 and rx_valid stays 1.
- Assert m_reset mid-DATA of frame 0xF0, release, send 0x5A -> no output for 0xF0; rx_data=8'h5A. End-to-end: uart_rx_deser driving uartprobe with byte 8'd2 (CMD_GPI_RD0) -> uartprobe tx_data equals gpi[7:0].
